// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate_bist self-test block.
package gate_bist_pkg;

    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/gate_bist_if.sv
// Control/result and gate-side signals of gate_bist, grouped as one bundle.
interface gate_bist_if #(
    parameter int unsigned N_IN = 2
);
    logic              start;
    logic              resp_i;
    logic [N_IN-1:0]   stim_o;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_cnt;
    logic [N_IN-1:0]   fail_idx;

    modport master (
        output start, resp_i,
        input  stim_o, busy, done, pass, err_cnt, fail_idx
    );

    modport slave (
        input  start, resp_i,
        output stim_o, busy, done, pass, err_cnt, fail_idx
    );
endinterface

// File: rtl/gate_bist_seq.sv
// Pattern counter and per-pattern settle down-counter for gate_bist.
module gate_bist_seq
    import gate_bist_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            adv,
    input  logic            drive,
    output logic [N_IN-1:0] pattern,
    output logic            last_pat,
    output logic            settle_zero
);
    localparam int unsigned          PAT_W  = N_IN + 1;
    localparam logic [PAT_W-1:0]     LAST   = PAT_W'((1 << N_IN) - 1);
    localparam logic [SETTLE_W-1:0]  RELOAD = SETTLE_W'(SETTLE);

    logic [PAT_W-1:0]    pat_q;
    logic [SETTLE_W-1:0] cnt_q;

    // One extra pattern bit keeps the terminal compare independent of wrap-around
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            pat_q <= '0;
            cnt_q <= RELOAD;
        end else if (adv) begin
            pat_q <= pat_q + PAT_W'(1);
            cnt_q <= RELOAD;
        end else if (drive && (cnt_q != '0)) begin
            cnt_q <= cnt_q - SETTLE_W'(1);
        end
    end

    assign pattern     = pat_q[N_IN-1:0];
    assign last_pat    = (pat_q == LAST);
    assign settle_zero = (cnt_q == '0);

endmodule

// File: rtl/gate_bist.sv
// Self-test sequencer/checker for a small combinational gate.
// Build option GATE_BIST_STOP_ON_FAIL_EN: end the run at the first mismatch.
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int unsigned               N_IN      = 2,
    parameter logic [(1 << N_IN)-1:0]    EXP_TABLE = 4'b1000,
    parameter int unsigned               SETTLE    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    gate_bist_if.slave  bus
);
    localparam int unsigned ERR_W = N_IN + 1;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [N_IN-1:0]   fidx_q, fidx_d;

    logic              load, adv, drive;
    logic [N_IN-1:0]   pattern;
    logic              last_pat, settle_zero;
    logic              mismatch_c, finish_c;

    gate_bist_seq #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .adv         (adv),
        .drive       (drive),
        .pattern     (pattern),
        .last_pat    (last_pat),
        .settle_zero (settle_zero)
    );

    // Case inequality so an X/Z response is scored as a mismatch in simulation
    assign mismatch_c = (bus.resp_i !== EXP_TABLE[pattern]);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    assign finish_c = last_pat || mismatch_c;
`else
    assign finish_c = last_pat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        load    = 1'b0;
        adv     = 1'b0;
        drive   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_DRIVE;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fidx_d  = '0;
                    load    = 1'b1;
                end
            end
            ST_DRIVE: begin
                drive = 1'b1;
                if (settle_zero) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mismatch_c) begin
                    err_d = err_q + ERR_W'(1);
                    if (err_q == '0) begin
                        fidx_d = pattern;
                    end
                end
                if (finish_c) begin
                    state_d = ST_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = ST_DRIVE;
                    adv     = 1'b1;
                end
            end
            ST_FINISH: begin
                // Clearing the pattern returns stim_o to 0 in the following cycle
                state_d = ST_IDLE;
                load    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.stim_o   = pattern;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_q;
    assign bus.fail_idx = fidx_q;

endmodule

// File: tb/tb_gate_bist.sv
// Directed scoreboard bench for gate_bist: two instances (2-input/settle 1, 3-input/settle 0).
module tb_gate_bist;

    logic clk;
    logic rst_n;
    int   mode;     // gate model for the 2-input DUT: 0 AND, 1 tied 1, 2 tied 0, 3 NAND

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int len;
        int pass;
        int err;
        int fidx;
    } res_t;

    res_t exp_q[$];
    int   stim_q[$];

    gate_bist_if #(.N_IN(2)) bus2 ();
    gate_bist_if #(.N_IN(3)) bus3 ();

    gate_bist #(.N_IN(2), .EXP_TABLE(4'b1000), .SETTLE(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    gate_bist #(.N_IN(3), .EXP_TABLE(8'h80), .SETTLE(0)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            0:       bus2.resp_i = &bus2.stim_o;
            1:       bus2.resp_i = 1'b1;
            2:       bus2.resp_i = 1'b0;
            default: bus2.resp_i = ~&bus2.stim_o;
        endcase
    end
    assign bus3.resp_i = &bus3.stim_o;

    function automatic bit gate_out(input int md, input int p, input int n);
        case (md)
            0:       return p == (1 << n) - 1;
            1:       return 1'b1;
            2:       return 1'b0;
            default: return p != (1 << n) - 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected run outcome and per-cycle stimulus, derived from the gate model and truth table
    task automatic push_expected(input int md, input int n, input int settle, input int tbl);
        res_t r;
        r.err  = 0;
        r.fidx = 0;
        for (int p = 0; p < (1 << n); p++) begin
            if (gate_out(md, p, n) != bit'((tbl >> p) & 1)) begin
                if (r.err == 0) r.fidx = p;
                r.err++;
            end
            for (int k = 0; k < settle + 2; k++) stim_q.push_back(p);
        end
        r.len  = (1 << n) * (settle + 2) + 1;
        r.pass = (r.err == 0) ? 1 : 0;
        exp_q.push_back(r);
    endtask

    task automatic sample(input int which, output logic [31:0] b, output logic [31:0] d,
                          output logic [31:0] ps, output logic [31:0] e,
                          output logic [31:0] f, output logic [31:0] s);
        if (which == 0) begin
            b = 32'(bus2.busy); d = 32'(bus2.done); ps = 32'(bus2.pass);
            e = 32'(bus2.err_cnt); f = 32'(bus2.fail_idx); s = 32'(bus2.stim_o);
        end else begin
            b = 32'(bus3.busy); d = 32'(bus3.done); ps = 32'(bus3.pass);
            e = 32'(bus3.err_cnt); f = 32'(bus3.fail_idx); s = 32'(bus3.stim_o);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) bus2.start = v;
        else            bus3.start = v;
    endtask

    task automatic kick(input int which, input bit hold);
        set_start(which, 1'b1);
        @(posedge clk); #1;
        if (!hold) set_start(which, 1'b0);
    endtask

    // Follows one run from its first DRIVE cycle to done, then the cycle after
    task automatic monitor(input int which, input int pulse_at);
        logic [31:0] b, d, ps, e, f, s, es;
        int   cyc;
        res_t r;
        cyc = 1;
        forever begin
            sample(which, b, d, ps, e, f, s);
            if (d === 32'd1) break;
            if (cyc >= 400) begin
                checks++;
                assert (d === 32'd1) else begin
                    fails++;
                    $error("FAIL done_timeout observed=%0h expected=1", d);
                end
                break;
            end
            es = (stim_q.size() > 0) ? 32'(stim_q.pop_front()) : 32'hFFFF_FFFF;
            check("stim_seq", s, es);
            check("busy_in_run", b, 32'd1);
            if (pulse_at > 0) begin
                if (cyc == pulse_at)          set_start(which, 1'b1);
                else if (cyc == pulse_at + 1) set_start(which, 1'b0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        r = exp_q.pop_front();
        check("run_len",       32'(cyc),    32'(r.len));
        check("busy_at_done",  b,           32'd0);
        check("pass_at_done",  ps,          32'(r.pass));
        check("err_cnt",       e,           32'(r.err));
        check("fail_idx",      f,           32'(r.fidx));
        @(posedge clk); #1;
        sample(which, b, d, ps, e, f, s);
        check("done_pulse_1cyc", d,  32'd0);
        check("stim_after",      s,  32'd0);
        check("pass_hold",       ps, 32'(r.pass));
        check("err_hold",        e,  32'(r.err));
        stim_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] b, d, ps, e, f, s;
        bit saw_done;

        rst_n      = 1'b0;
        mode       = 0;
        bus2.start = 1'b0;
        bus3.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sample(0, b, d, ps, e, f, s);
        check("rst_busy", b, 0); check("rst_done", d, 0); check("rst_pass", ps, 0);
        check("rst_err", e, 0);  check("rst_fidx", f, 0); check("rst_stim", s, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // AND gate against AND table
        mode = 0; push_expected(0, 2, 1, 8); kick(0, 0); monitor(0, 0);
        // resp tied high: patterns 0..2 mismatch
        mode = 1; push_expected(1, 2, 1, 8); kick(0, 0); monitor(0, 0);
        // resp tied low: only the last pattern mismatches
        mode = 2; push_expected(2, 2, 1, 8); kick(0, 0); monitor(0, 0);
        // NAND: every pattern mismatches, err_cnt reaches 2^N_IN
        mode = 3; push_expected(3, 2, 1, 8); kick(0, 0); monitor(0, 0);

        // Reset in the middle of pattern 2
        mode = 0;
        kick(0, 0);
        for (int i = 0; i < 50; i++) begin
            if (bus2.stim_o == 2'd2) break;
            @(posedge clk); #1;
        end
        check("reach_pat2", 32'(bus2.stim_o), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        sample(0, b, d, ps, e, f, s);
        check("abort_busy", b, 0); check("abort_done", d, 0); check("abort_pass", ps, 0);
        check("abort_err", e, 0);  check("abort_fidx", f, 0); check("abort_stim", s, 0);
        @(negedge clk) rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus2.done === 1'b1 || bus2.busy === 1'b1) saw_done = 1'b1;
        end
        check("no_activity_after_abort", 32'(saw_done), 0);
        push_expected(0, 2, 1, 8); kick(0, 0); monitor(0, 0);

        // start pulsed mid-run is ignored
        push_expected(0, 2, 1, 8); kick(0, 0); monitor(0, 5);

        // start held through FINISH: failing run, then an immediate clean run
        mode = 1; push_expected(1, 2, 1, 8); kick(0, 1); monitor(0, 0);
        mode = 0; push_expected(0, 2, 1, 8);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        sample(0, b, d, ps, e, f, s);
        check("restart_busy", b, 1);
        check("restart_err_cleared", e, 0);
        check("restart_pass_cleared", ps, 0);
        monitor(0, 0);

        // 3-input AND, no settle cycles
        push_expected(0, 3, 0, 32'h80); kick(1, 0); monitor(1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
